// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, bus sizes, grant ids.
// The round-robin option is selected with MEM_ARB_RR_EN in the top module.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic GRANT_I_ID = 1'b0;
  localparam logic GRANT_D_ID = 1'b1;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Grant watchdog: counts wait cycles of one bus access and flags the cycle
// in which the count reaches LIMIT.
module mem_arb_timeout #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry fires on the wait cycle whose increment would reach LIMIT, so the
  // abort lands exactly LIMIT wait cycles after the grant.
  assign expire = inc && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (I) and data (D) requesters.
// Define MEM_ARB_RR_EN for round-robin on contention; default is D-over-I priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready_n,
  input  logic        m_busy,
  output logic        timeout_err
);

  arb_state_t  state, state_nxt;
  bus_req_t    bus_p1, bus_nxt;
  logic        m_req_p1, m_req_nxt;
  logic        i_done_p1, i_done_nxt;
  logic        d_done_p1, d_done_nxt;
  logic [31:0] i_rdata_p1, i_rdata_nxt;
  logic [31:0] d_rdata_p1, d_rdata_nxt;
  logic        err_p1, err_nxt;
  logic        i_elig, d_elig, pick_d, pick_i, grant_any;
  logic        tmo_clr, tmo_inc, tmo_expire;

  // A requester showing done is still holding the access just finished.
  assign i_elig = i_req & ~i_done_p1;
  assign d_elig = d_req & ~d_done_p1;

`ifdef MEM_ARB_RR_EN
  logic last_grant_p1;

  assign pick_d = d_elig & (~i_elig | (last_grant_p1 != GRANT_D_ID));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_p1 <= GRANT_D_ID;
    end else if (grant_any) begin
      last_grant_p1 <= pick_d ? GRANT_D_ID : GRANT_I_ID;
    end
  end
`else
  assign pick_d = d_elig;
`endif

  assign pick_i    = i_elig & ~pick_d;
  assign grant_any = (state == IDLE) & ~m_busy & (pick_d | pick_i);
  assign tmo_clr   = grant_any;
  assign tmo_inc   = (state != IDLE) & m_ready_n;

  always_comb begin
    state_nxt   = state;
    bus_nxt     = bus_p1;
    m_req_nxt   = m_req_p1;
    i_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    i_rdata_nxt = i_rdata_p1;
    d_rdata_nxt = d_rdata_p1;
    err_nxt     = err_p1;
    case (state)
      IDLE: begin
        if (grant_any) begin
          m_req_nxt = 1'b1;
          if (pick_d) begin
            state_nxt     = GRANT_D;
            bus_nxt.write = d_write;
            bus_nxt.size  = d_size;
            bus_nxt.addr  = d_addr;
            bus_nxt.wdata = d_write ? d_wdata : '0;
          end else begin
            state_nxt     = GRANT_I;
            bus_nxt.write = 1'b0;
            bus_nxt.size  = SIZE_W;
            bus_nxt.addr  = i_addr;
            bus_nxt.wdata = '0;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (~m_ready_n || tmo_expire) begin
          state_nxt = IDLE;
          bus_nxt   = '0;
          m_req_nxt = 1'b0;
          if (state == GRANT_I) begin
            i_done_nxt = 1'b1;
          end else begin
            d_done_nxt = 1'b1;
          end
          // A real answer in the expiry cycle counts as a normal completion.
          if (~m_ready_n) begin
            if (state == GRANT_I) begin
              i_rdata_nxt = m_rdata;
            end else if (~bus_p1.write) begin
              d_rdata_nxt = m_rdata;
            end
          end else begin
            err_nxt = 1'b1;
            if (state == GRANT_I) begin
              i_rdata_nxt = '0;
            end else begin
              d_rdata_nxt = '0;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        bus_nxt   = '0;
        m_req_nxt = 1'b0;
      end
    endcase
  end

  // Stage p1: registered bus request, completion pulses and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus_p1     <= '0;
      m_req_p1   <= 1'b0;
      i_done_p1  <= 1'b0;
      d_done_p1  <= 1'b0;
      i_rdata_p1 <= '0;
      d_rdata_p1 <= '0;
      err_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus_p1     <= bus_nxt;
      m_req_p1   <= m_req_nxt;
      i_done_p1  <= i_done_nxt;
      d_done_p1  <= d_done_nxt;
      i_rdata_p1 <= i_rdata_nxt;
      d_rdata_p1 <= d_rdata_nxt;
      err_p1     <= err_nxt;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      mem_arb_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
      ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
      );
    end else begin : g_no_tmo
      logic tmo_unused;
      assign tmo_unused = tmo_clr ^ tmo_inc;
      assign tmo_expire = 1'b0;
    end
  endgenerate

  assign m_req       = m_req_p1;
  assign m_write     = bus_p1.write;
  assign m_size      = bus_p1.size;
  assign m_addr      = bus_p1.addr;
  assign m_wdata     = bus_p1.wdata;
  assign i_rdata     = i_rdata_p1;
  assign d_rdata     = d_rdata_p1;
  assign i_done      = i_done_p1;
  assign d_done      = d_done_p1;
  assign timeout_err = err_p1;
  assign i_stall     = i_req & ~i_done_p1;
  assign d_stall     = d_req & ~d_done_p1;

endmodule
